alu_cmd_sequencer: RTL

//   Initiator side of the ALU operand/opcode interface. Buffers tagged ALU commands from a

---
 rtl/alu_cmd_sequencer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/alu_cmd_sequencer.sv
// Tagged ALU command sequencer: buffers commands, drives the ALU for ALU_LATENCY cycles and returns the result with its tag.
// Optional `ALU_CMD_ERRCHK_EN rejects op 111 and DIV-by-zero without touching the ALU bus.

module alu_cmd_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_dat,
  input  logic         i_pop,
  output logic [W-1:0] o_dat,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_cnt == FULL_CNT);
  assign o_empty = (r_cnt == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_dat   = r_mem[r_rp];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

module alu_cmd_sequencer #(
  parameter int WIDTH       = 32,
  parameter int TAG_W       = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int ALU_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [2:0]       i_cmd_op,
  input  logic [WIDTH-1:0] i_cmd_a,
  input  logic [WIDTH-1:0] i_cmd_b,
  input  logic [TAG_W-1:0] i_cmd_tag,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic [2:0]       o_alu_op,
  input  logic [WIDTH-1:0] i_alu_result,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [WIDTH-1:0] o_rsp_data,
  output logic [TAG_W-1:0] o_rsp_tag,
  output logic             o_rsp_err
);
  localparam int CW = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(ALU_LATENCY - 1);

  typedef struct packed {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_live;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [2:0]       r_alu_op;
  logic [TAG_W-1:0] r_tag;
  logic             r_rsp_vld;
  logic [WIDTH-1:0] r_rsp_data;
  logic [TAG_W-1:0] r_rsp_tag;
  logic             r_rsp_err;

  cmd_t w_in;
  cmd_t w_head;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_reject;

  assign w_in        = '{op: i_cmd_op, a: i_cmd_a, b: i_cmd_b, tag: i_cmd_tag};
  // r_live keeps cmd_ready low until the first edge after reset release.
  assign o_cmd_ready = r_live & ~w_full;
  assign w_push      = i_cmd_valid & o_cmd_ready;
  assign w_pop       = (r_state == S_IDLE) & ~w_empty;

`ifdef ALU_CMD_ERRCHK_EN
  assign w_reject = (w_head.op == 3'b111) || ((w_head.op == 3'b110) && (w_head.b == '0));
`else
  assign w_reject = 1'b0;
`endif

  alu_cmd_fifo #(.W($bits(cmd_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_dat   (w_in),
    .i_pop   (w_pop),
    .o_dat   (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_live     <= 1'b0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_op   <= '0;
      r_tag      <= '0;
      r_rsp_vld  <= 1'b0;
      r_rsp_data <= '0;
      r_rsp_tag  <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      r_live <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            if (w_reject) begin
              r_rsp_data <= '0;
              r_rsp_tag  <= w_head.tag;
              r_rsp_err  <= 1'b1;
              r_rsp_vld  <= 1'b1;
              r_state    <= S_RESP;
            end else begin
              r_alu_a  <= w_head.a;
              r_alu_b  <= w_head.b;
              r_alu_op <= w_head.op;
              r_tag    <= w_head.tag;
              r_cnt    <= CNT_INIT;
              r_state  <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (r_cnt == '0) begin
            r_rsp_data <= i_alu_result;
            r_rsp_tag  <= r_tag;
            r_rsp_err  <= 1'b0;
            r_rsp_vld  <= 1'b1;
            r_state    <= S_RESP;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_RESP: begin
          if (i_rsp_ready) begin
            r_rsp_vld <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_alu_a     = r_alu_a;
  assign o_alu_b     = r_alu_b;
  assign o_alu_op    = r_alu_op;
  assign o_rsp_valid = r_rsp_vld;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_tag   = r_rsp_tag;
  assign o_rsp_err   = r_rsp_err;
endmodule
